// File: rtl/led_pattern_gen.sv
// Multi-mode LED driver: off, running light, blink-all and PWM breathe.
// A debounced active-low push key steps through the modes in order.
module led_pattern_gen #(
    parameter int LED_NUM         = 4,
    parameter int STEP_CYCLES     = 25_000_000,
    parameter int DEB_CYCLES      = 1_000_000,
    parameter int PWM_BITS        = 8,
    parameter int BREATHE_PERIODS = 4,
    parameter int LED_ACT_HIGH    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key,
    output logic [1:0]         mode,
    output logic [LED_NUM-1:0] led
);

    localparam int STEP_W = $clog2(STEP_CYCLES + 1);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int PER_W  = $clog2(BREATHE_PERIODS + 1);

    localparam logic [STEP_W-1:0]  STEP_LAST    = STEP_W'(STEP_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST     = DEB_W'(DEB_CYCLES - 1);
    localparam logic [PER_W-1:0]   PER_LAST     = PER_W'(BREATHE_PERIODS - 1);
    localparam logic [LED_NUM-1:0] PATTERN_INIT = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] LED_OFF      = (LED_ACT_HIGH != 0) ? {LED_NUM{1'b0}} : {LED_NUM{1'b1}};

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_RUN     = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } modeState_t;

    modeState_t          r_mode;
    modeState_t          w_modeNext;
    logic [1:0]          r_keySync;
    logic                r_keyLevel;
    logic [DEB_W-1:0]    r_debCnt;
    logic [STEP_W-1:0]   r_stepCnt;
    logic [LED_NUM-1:0]  r_pattern;
    logic                r_phase;
    logic [PWM_BITS-1:0] r_pwmCnt;
    logic [PER_W-1:0]    r_perCnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_dirUp;
    logic [LED_NUM-1:0]  r_led;

    logic                w_keySynced;
    logic                w_keyDiff;
    logic                w_debDone;
    logic                w_press;
    logic                w_stepEnd;
    logic                w_tick;
    logic                w_pwmWrap;
    logic                w_dutyStep;
    logic [LED_NUM-1:0]  w_ledLogical;

    assign w_keySynced = r_keySync[1];
    assign w_keyDiff   = (w_keySynced != r_keyLevel);
    assign w_debDone   = w_keyDiff && (r_debCnt == DEB_LAST);
    assign w_press     = w_debDone && !w_keySynced;
    assign w_stepEnd   = (r_stepCnt == STEP_LAST);
    assign w_tick      = w_stepEnd && !w_press;
    assign w_pwmWrap   = (r_pwmCnt == {PWM_BITS{1'b1}});
    assign w_dutyStep  = w_pwmWrap && (r_perCnt == PER_LAST) && (r_mode == MODE_BREATHE);

    assign mode = r_mode;
    assign led  = r_led;

    // Two-flop synchroniser for the asynchronous key, idling at the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keySync <= 2'b11;
        end else begin
            r_keySync <= {r_keySync[0], key};
        end
    end

    // Debounce: accept a new key level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_debCnt   <= '0;
            r_keyLevel <= 1'b1;
        end else if (!w_keyDiff) begin
            r_debCnt <= '0;
        end else if (w_debDone) begin
            r_debCnt   <= '0;
            r_keyLevel <= w_keySynced;
        end else begin
            r_debCnt <= r_debCnt + DEB_W'(1);
        end
    end

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_modeNext;
        end
    end

    // Next mode: each accepted press advances one mode, wrapping breathe back to off.
    always_comb begin
        w_modeNext = r_mode;
        if (w_press) begin
            unique case (r_mode)
                MODE_OFF:     w_modeNext = MODE_RUN;
                MODE_RUN:     w_modeNext = MODE_BLINK;
                MODE_BLINK:   w_modeNext = MODE_BREATHE;
                MODE_BREATHE: w_modeNext = MODE_OFF;
                default:      w_modeNext = MODE_OFF;
            endcase
        end
    end

    // Pattern step timer; a mode change restarts it so a new pattern gets a full first step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stepCnt <= '0;
        end else if (w_press || w_stepEnd) begin
            r_stepCnt <= '0;
        end else begin
            r_stepCnt <= r_stepCnt + STEP_W'(1);
        end
    end

    // Running-light pattern and blink phase, both advanced only by ticks in their own mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= PATTERN_INIT;
            r_phase   <= 1'b0;
        end else if (w_press) begin
            r_pattern <= PATTERN_INIT;
            r_phase   <= 1'b0;
        end else if (w_tick) begin
            if (r_mode == MODE_RUN) begin
                r_pattern <= {r_pattern[LED_NUM-2:0], r_pattern[LED_NUM-1]};
            end
            if (r_mode == MODE_BLINK) begin
                r_phase <= !r_phase;
            end
        end
    end

    // Free-running PWM counter plus a count of completed PWM periods.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwmCnt <= '0;
            r_perCnt <= '0;
        end else if (w_press) begin
            r_pwmCnt <= '0;
            r_perCnt <= '0;
        end else begin
            r_pwmCnt <= r_pwmCnt + PWM_BITS'(1);
            if (w_pwmWrap) begin
                r_perCnt <= (r_perCnt == PER_LAST) ? '0 : r_perCnt + PER_W'(1);
            end
        end
    end

    // Breathe duty ramp: triangle that holds each endpoint for one step instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty  <= '0;
            r_dirUp <= 1'b1;
        end else if (w_press) begin
            r_duty  <= '0;
            r_dirUp <= 1'b1;
        end else if (w_dutyStep) begin
            if (r_dirUp) begin
                if (r_duty == {PWM_BITS{1'b1}}) begin
                    r_dirUp <= 1'b0;
                end else begin
                    r_duty <= r_duty + PWM_BITS'(1);
                end
            end else begin
                if (r_duty == '0) begin
                    r_dirUp <= 1'b1;
                end else begin
                    r_duty <= r_duty - PWM_BITS'(1);
                end
            end
        end
    end

    // Logical LED image for the current mode, before polarity is applied.
    always_comb begin
        w_ledLogical = '0;
        unique case (r_mode)
            MODE_OFF:     w_ledLogical = '0;
            MODE_RUN:     w_ledLogical = r_pattern;
            MODE_BLINK:   w_ledLogical = r_phase ? {LED_NUM{1'b1}} : {LED_NUM{1'b0}};
            MODE_BREATHE: w_ledLogical = (r_pwmCnt < r_duty) ? {LED_NUM{1'b1}} : {LED_NUM{1'b0}};
            default:      w_ledLogical = '0;
        endcase
    end

    // Registered pin drive with board polarity applied as the final stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= LED_OFF;
        end else if (LED_ACT_HIGH != 0) begin
            r_led <= w_ledLogical;
        end else begin
            r_led <= ~w_ledLogical;
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised multi-mode LED driver, the next generation of the board's fixed 4-LED blinker.
- Drives LED_NUM LEDs in one of four modes: off, running light, blink-all, or breathe (PWM triangle).
- A debounced push-key cycles through the modes.
- Sits directly at board pins, fed by the 50 MHz system clock.

Parameters:
- LED_NUM, 4, number of LED outputs (2..32)
- STEP_CYCLES, 25_000_000, clock cycles per pattern step (500 ms at 50 MHz)
- DEB_CYCLES, 1_000_000, consecutive stable cycles required to accept a key level change (20 ms)
- PWM_BITS, 8, PWM counter/duty width for breathe mode
- BREATHE_PERIODS, 4, PWM periods per duty step in breathe mode
- LED_ACT_HIGH, 1, 1 = LED lit by logic 1; 0 = all led bits inverted at output

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-high reset
- key, input, 1, raw push key, active-low, asynchronous to clk
- mode, output, 2, current mode: 0 off, 1 running, 2 blink, 3 breathe
- led, output, LED_NUM, registered LED drive

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst clears all state immediately, independent of clk.
  - While rst is high: mode=1, pattern register={LED_NUM-1 zeros,1}, all counters=0, debounced key level=1, breathe direction=up, led=all-off (0 if LED_ACT_HIGH else all ones).
- Key path:
  - 2-FF synchroniser.
  - Debounce counter increments while the synced level differs from the accepted level; clears when they match.
  - On the cycle the count reaches DEB_CYCLES-1 with the level still differing, the accepted level updates and the counter clears.
  - A press event is a 1->0 transition of the accepted level. Releases generate no event.
  - On a press, mode increments modulo 4 (3 wraps to 0) on the next edge.
  - Glitches shorter than DEB_CYCLES produce no event.
- Step tick:
  - Counter runs 0..STEP_CYCLES-1; tick is a 1-cycle pulse at STEP_CYCLES-1, then the counter wraps to 0.
  - Any mode change clears the step counter, the PWM counter, the period counter and duty, sets direction=up, and reloads the pattern to {0..0,1}.
- Mode 0: led all-off.
- Mode 1, running light:
  - led=pattern.
  - On each tick, pattern rotates left by 1; bit LED_NUM-1 wraps to bit 0.
  - Exactly one LED is lit at all times.
- Mode 2, blink:
  - Internal phase bit starts at 0 on mode entry (all off) and toggles on each tick.
  - led = all-on when phase=1, else all-off.
- Mode 3, breathe:
  - pwm_cnt is free-running with width PWM_BITS.
  - A period ends when pwm_cnt wraps from max to 0; every BREATHE_PERIODS period ends, duty steps by 1.
  - Direction up: duty increments until 2^PWM_BITS-1, then direction flips to down.
  - Direction down: duty decrements until 0, then direction flips to up.
  - The endpoint value is held for one step before reversing; no overshoot or wrap.
  - All LEDs lit when pwm_cnt < duty. duty=0 gives fully off.
- Output: led is registered with one cycle latency from internal state. Polarity is applied last.
- The mode output reflects the mode register directly.
- Simultaneous press and tick: the mode change wins; the tick is discarded.

Test Plan (bench overrides: STEP_CYCLES=10, DEB_CYCLES=5, PWM_BITS=3, BREATHE_PERIODS=1, LED_NUM=4):
- Reset: assert rst mid-run, then release -> led=0000 and mode=1 while rst is high; led=0001 one cycle after release; 0010, 0100, 1000, 0001 at successive 10-cycle ticks (wrap-around).
- Debounce: key low for 3 cycles -> mode stays 1. Key low for 8 cycles -> mode=2 exactly once. Hold key low 100 cycles -> no further change. Release -> no change.
- Mode cycling: four clean presses -> mode sequence 2, 3, 0, 1. Mode 0 -> led=0000 constantly. Mode 2 -> led 0000 for 10 cycles, then 1111, then toggles every 10 cycles.
- Breathe ramp: enter mode 3 and measure the lit-cycle count per 8-cycle PWM period -> 0, 1, 2 … 7, 7, 6 … 0, 0, 1 (triangle with endpoints held, no wrap).
- Mode change mid-pattern: press while running pattern=0100 at step count 7 -> blink restarts, first toggle exactly 10 cycles after the mode change. Press coinciding with a tick -> no extra rotation or toggle.
- Polarity: LED_ACT_HIGH=0 -> led=1111 in reset; running shows 1110, 1101, 1011, 0111.
